// File: rtl/adder_seq_pkg.sv
// Shared word width and FSM encoding for the word-serial wide adder.
package adder_seq_pkg;

    localparam int WORD_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } state_t;

endpackage

// File: rtl/adder_64_bit_sequencer_cla16.sv
// 16-bit adder with 4-bit group look-ahead carry; outputs float when not enabled.
module Adder_with_Look_Ahead_Carry_Generator_16_Bit
    import adder_seq_pkg::*;
(
    input  logic                  Enable_In,
    input  logic [WORD_WIDTH-1:0] A_In,
    input  logic [WORD_WIDTH-1:0] B_In,
    input  logic                  Carry_In,
    output logic [WORD_WIDTH-1:0] Sum_Out,
    output logic                  Carry_Out
);

    localparam int GROUPS = WORD_WIDTH / 4;

    logic [WORD_WIDTH-1:0] p;
    logic [WORD_WIDTH-1:0] g;
    logic [WORD_WIDTH:0]   c;
    logic [GROUPS-1:0]     grp_p;
    logic [GROUPS-1:0]     grp_g;
    logic [GROUPS:0]       grp_c;
    logic [WORD_WIDTH-1:0] sum;

    assign p = A_In ^ B_In;
    assign g = A_In & B_In;

    // Group generate/propagate let each group's carry-in resolve without
    // waiting on the bit carries of the groups below it.
    always_comb begin
        grp_p = '0;
        grp_g = '0;
        for (int k = 0; k < GROUPS; k++) begin
            grp_p[k] = &p[4*k +: 4];
            grp_g[k] = g[4*k+3]
                     | (p[4*k+3] & g[4*k+2])
                     | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    always_comb begin
        grp_c    = '0;
        grp_c[0] = Carry_In;
        for (int k = 0; k < GROUPS; k++) begin
            grp_c[k+1] = grp_g[k] | (grp_p[k] & grp_c[k]);
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < GROUPS; k++) begin
            c[4*k]   = grp_c[k];
            c[4*k+1] = g[4*k]   | (p[4*k]   & grp_c[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k])
                     | (p[4*k+1] & p[4*k] & grp_c[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
                     | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & grp_c[k]);
        end
        c[WORD_WIDTH] = grp_c[GROUPS];
    end

    assign sum = p ^ c[WORD_WIDTH-1:0];

    assign Sum_Out   = Enable_In ? sum : {WORD_WIDTH{1'bz}};
    assign Carry_Out = Enable_In ? c[WORD_WIDTH] : 1'bz;

endmodule

// File: rtl/adder_64_bit_sequencer.sv
// Word-serial wide adder: one shared 16-bit CLA is stepped over WORDS beats per operand set.
//
//  state   | meaning
//  IDLE    | ready for an operand set (In_Ready_Out=1)
//  COMPUTE | one 16-bit word added per clock, LSB word first
//  DONE    | result presented (Out_Valid_Out=1) until Out_Ready_In
module adder_64_bit_sequencer
    import adder_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                      Clock_In,
    input  logic                      Reset_n_In,
    input  logic                      In_Valid_In,
    output logic                      In_Ready_Out,
    input  logic [WORD_WIDTH*WORDS-1:0] Data_A_In,
    input  logic [WORD_WIDTH*WORDS-1:0] Data_B_In,
    input  logic                      Carry_In,
    output logic                      Out_Valid_Out,
    input  logic                      Out_Ready_In,
    output logic [WORD_WIDTH*WORDS-1:0] Sum_Out,
    output logic                      Carry_Out,
    output logic                      Overflow_Out
);

    localparam int OP_W   = WORD_WIDTH * WORDS;
    localparam int BEAT_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS - 1);

    state_t              state;
    logic [BEAT_W-1:0]   beat;
    logic [OP_W-1:0]     a_q;
    logic [OP_W-1:0]     b_q;
    logic                cin_q;
    logic                carry_q;

    logic                  add_en;
    logic [WORD_WIDTH-1:0] add_a;
    logic [WORD_WIDTH-1:0] add_b;
    logic                  add_cin;
    logic [WORD_WIDTH-1:0] add_sum;
    logic                  add_cout;

    assign In_Ready_Out  = (state == IDLE);
    assign Out_Valid_Out = (state == DONE);

    assign add_en  = (state == COMPUTE);
    assign add_a   = a_q[int'(beat)*WORD_WIDTH +: WORD_WIDTH];
    assign add_b   = b_q[int'(beat)*WORD_WIDTH +: WORD_WIDTH];
    assign add_cin = (beat == '0) ? cin_q : carry_q;

    Adder_with_Look_Ahead_Carry_Generator_16_Bit u_cla16 (
        .Enable_In (add_en),
        .A_In      (add_a),
        .B_In      (add_b),
        .Carry_In  (add_cin),
        .Sum_Out   (add_sum),
        .Carry_Out (add_cout)
    );

    // Adder outputs are only read in COMPUTE, when the adder is enabled.
    always_ff @(posedge Clock_In or negedge Reset_n_In) begin
        if (!Reset_n_In) begin
            state        <= IDLE;
            beat         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            cin_q        <= 1'b0;
            carry_q      <= 1'b0;
            Sum_Out      <= '0;
            Carry_Out    <= 1'b0;
            Overflow_Out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (In_Valid_In) begin
                        a_q   <= Data_A_In;
                        b_q   <= Data_B_In;
                        cin_q <= Carry_In;
                        beat  <= '0;
                        state <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    Sum_Out[int'(beat)*WORD_WIDTH +: WORD_WIDTH] <= add_sum;
                    carry_q <= add_cout;
                    if (beat == LAST_BEAT) begin
                        Carry_Out    <= add_cout;
                        Overflow_Out <= (a_q[OP_W-1] == b_q[OP_W-1])
                                      & (add_sum[WORD_WIDTH-1] != a_q[OP_W-1]);
                        state        <= DONE;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                DONE: begin
                    if (Out_Ready_In) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_64_bit_sequencer.sv
// Directed-vector and random checks for the word-serial 64-bit adder sequencer.
`timescale 1ns/1ps
module tb_adder_64_bit_sequencer;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] data_a;
    logic [63:0] data_b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int tests_run = 0;
    int tests_failed = 0;

    adder_64_bit_sequencer #(.WORDS(4)) dut (
        .Clock_In      (clk),
        .Reset_n_In    (rst_n),
        .In_Valid_In   (in_valid),
        .In_Ready_Out  (in_ready),
        .Data_A_In     (data_a),
        .Data_B_In     (data_b),
        .Carry_In      (cin),
        .Out_Valid_Out (out_valid),
        .Out_Ready_In  (out_ready),
        .Sum_Out       (sum),
        .Carry_Out     (cout),
        .Overflow_Out  (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Present operands and hold In_Valid until an edge with In_Ready high accepts them.
    task automatic apply(input logic [63:0] a, input logic [63:0] b, input logic c);
        logic rdy;
        int   n;
        data_a   = a;
        data_b   = b;
        cin      = c;
        in_valid = 1'b1;
        n = 0;
        forever begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy || n >= 40) break;
            n++;
        end
        if (n >= 40) check("accept_timeout", 64'(n), 64'd0);
        in_valid = 1'b0;
    endtask

    // Called just after the accept edge; counts edges until Out_Valid rises.
    task automatic wait_result(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run_and_check(input string name, input logic [63:0] a, input logic [63:0] b,
                                 input logic c, input logic [63:0] es, input logic ec, input logic eo);
        int lat;
        apply(a, b, c);
        wait_result(lat);
        check({name, "_latency"}, 64'(lat), 64'd4);
        check({name, "_sum"}, sum, es);
        check({name, "_cout"}, 64'(cout), 64'(ec));
        check({name, "_ovf"}, 64'(ovf), 64'(eo));
        release_result();
    endtask

    initial begin
        logic [63:0] held_sum;
        logic        hold_ok;
        logic [64:0] gold;
        logic [63:0] ra, rb;
        logic        rc, eo;
        int          lat;

        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2] = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
        vecs[3] = '{64'h0, 64'h0, 1'b0, 64'h0, 1'b0, 1'b0};
        vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
        vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 64'h0, 1'b1, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        data_a    = '0;
        data_b    = '0;
        cin       = 1'b0;
        #1;
        check("reset_ready", 64'(in_ready), 64'd1);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_sum", sum, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            run_and_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                          vecs[i].exp_sum, vecs[i].exp_cout, vecs[i].exp_ovf);
        end

        // Backpressure: result must hold and new operands be ignored while DONE.
        apply(64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b0);
        wait_result(lat);
        check("bp_latency", 64'(lat), 64'd4);
        held_sum = sum;
        check("bp_sum", held_sum, 64'h0000_0004_0000_0006);
        data_a   = 64'h0000_0000_0000_00AA;
        data_b   = 64'h0000_0000_0000_0055;
        cin      = 1'b1;
        in_valid = 1'b1;
        hold_ok  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (sum !== held_sum || in_ready !== 1'b0 || out_valid !== 1'b1) hold_ok = 1'b0;
        end
        check("bp_hold", 64'(hold_ok), 64'd1);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("bp_to_idle", 64'(in_ready), 64'd1);
        run_and_check("bp_next", 64'h0000_0000_0000_00AA, 64'h0000_0000_0000_0055, 1'b1,
                      64'h0000_0000_0000_0100, 1'b0, 1'b0);

        // Reset mid-compute at beat 2; outputs clear with no clock edge.
        apply(64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_sum", sum, 64'd0);
        check("rst_mid_flags", {61'd0, out_valid, cout, ovf}, 64'd0);
        check("rst_mid_ready", 64'(in_ready), 64'd1);
        data_a   = 64'h0000_0000_0000_0005;
        data_b   = 64'h0000_0000_0000_0007;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check("post_rst", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0,
                      64'h0000_0000_0000_000C, 1'b0, 1'b0);

        // Random operations with random valid/ready timing and junk inputs mid-operation.
        for (int i = 0; i < 200; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom_range(0, 1));
            gold = {1'b0, ra} + {1'b0, rb} + {64'd0, rc};
            eo = (ra[63] == rb[63]) && (gold[63] != ra[63]);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            apply(ra, rb, rc);
            data_a   = {$urandom(), $urandom()};
            data_b   = {$urandom(), $urandom()};
            cin      = 1'($urandom_range(0, 1));
            in_valid = 1'($urandom_range(0, 1));
            wait_result(lat);
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            in_valid = 1'b0;
            check($sformatf("rand%0d", i), {lat[3:0], 3'd0, ovf, 7'd0, cout, sum[47:0]},
                  {4'd4, 3'd0, eo, 7'd0, gold[64], gold[47:0]});
            check($sformatf("rand%0d_hi", i), {48'd0, sum[63:48]}, {48'd0, gold[63:48]});
            release_result();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/adder_64_bit_sequencer.md
ADDER_64_BIT_SEQUENCER -- requirements
Module: adder_64_bit_sequencer

Interface
REQ-001 Parameter WORDS, default 4: number of 16-bit beats per operation; operand width = 16*WORDS.
REQ-002 Clock_In  input  1  single clock; all state changes on its rising edge.
REQ-003 Reset_n_In  input  1  reset, asynchronous, active-low.
REQ-004 In_Valid_In  input  1  operand set presented.
REQ-005 In_Ready_Out  output  1  sequencer can accept an operand set.
REQ-006 Data_A_In  input  16*WORDS  operand A.
REQ-007 Data_B_In  input  16*WORDS  operand B.
REQ-008 Carry_In  input  1  carry into bit 0.
REQ-009 Out_Valid_Out  output  1  result valid.
REQ-010 Out_Ready_In  input  1  consumer takes result.
REQ-011 Sum_Out  output  16*WORDS  registered sum.
REQ-012 Carry_Out  output  1  registered carry out of MSB.
REQ-013 Overflow_Out  output  1  registered two's-complement signed overflow.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, COMPUTE, DONE.
REQ-015 In_Ready_Out SHALL be 1 only in IDLE; Out_Valid_Out SHALL be 1 only in DONE; both are decoded from state alone.
REQ-016 Accept = In_Valid_In & In_Ready_Out at a rising edge: capture Data_A_In, Data_B_In, Carry_In; clear beat counter to 0; go to COMPUTE.
REQ-017 In COMPUTE, the 16-bit adder SHALL receive Enable_In=1, A word[beat], B word[beat], carry = captured Carry_In when beat=0, else the carry register.
REQ-018 Each COMPUTE edge: Sum word[beat] <= adder Sum_Out; carry register <= adder Carry_Out; beat increments; at beat=WORDS-1 go to DONE instead.
REQ-019 On the final beat, Carry_Out <= adder Carry_Out and Overflow_Out <= (A[MSB]==B[MSB]) & (adder Sum_Out[15]!=A[MSB]).
REQ-020 Latency: Out_Valid_Out SHALL rise exactly WORDS cycles after the accept edge; WORDS=4 gives 4 cycles.
REQ-021 In IDLE and DONE the adder Enable_In SHALL be 0; its tri-stated outputs SHALL never be sampled.
REQ-022 In DONE, Sum_Out, Carry_Out and Overflow_Out SHALL hold stable until Out_Ready_In=1 at an edge, then go to IDLE.
REQ-023 Outputs SHALL retain the last result in IDLE and COMPUTE; Sum_Out words are updated beat by beat and are valid only while Out_Valid_Out=1.
REQ-024 In_Valid_In outside IDLE SHALL be ignored; operands are never re-sampled mid-operation.
REQ-025 Minimum spacing between accepts SHALL be WORDS+2 cycles (IDLE, WORDS x COMPUTE, DONE).
REQ-026 Arithmetic SHALL be modulo 2^(16*WORDS); {Carry_Out, Sum_Out} = A + B + Carry_In exactly.

Reset
REQ-027 Reset_n_In=0 SHALL immediately force state IDLE, beat 0, carry register 0, Sum_Out 0, Carry_Out 0, Overflow_Out 0, Out_Valid_Out 0, In_Ready_Out 1.
REQ-028 Reset asserted mid-COMPUTE or in DONE SHALL discard the operation; no partial result is presented after release.
REQ-029 The first accept SHALL be possible on the first rising edge after Reset_n_In deasserts.

Structure
REQ-030 Package adder_seq_pkg SHALL hold WORD_WIDTH=16 and the state enum (IDLE, COMPUTE, DONE).
REQ-031 The sole sub-module SHALL be the existing Adder_with_Look_Ahead_Carry_Generator_16_Bit, instantiated once and shared across beats.
REQ-032 Beat counter width SHALL be $clog2(WORDS) bits, minimum 1.

Verification
REQ-033 Reset: drive Reset_n_In=0 mid-stream -> Out_Valid_Out=0, Sum_Out=0, Carry_Out=0, Overflow_Out=0, In_Ready_Out=1 without a clock edge.
REQ-034 A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Cin=0 -> Sum=0x0, Carry=1, Overflow=0, Out_Valid 4 cycles after accept.
REQ-035 A=0x7FFF_FFFF_FFFF_FFFF, B=0x1, Cin=0 -> Sum=0x8000_0000_0000_0000, Carry=0, Overflow=1.
REQ-036 A=0x0000_0000_0000_FFFF, B=0x0, Cin=1 -> Sum=0x0000_0000_0001_0000 (carry crosses word boundary), Carry=0.
REQ-037 Backpressure: Out_Ready_In=0 for 10 cycles with In_Valid_In=1 and new operands -> result held, In_Ready_Out=0, new operands ignored; Out_Ready_In=1 -> IDLE, next accept produces the new result.
REQ-038 Reset pulse at beat 2 of an operation, then 200 random operations with random In_Valid/Out_Ready -> every result matches the golden A+B+Cin, and Passed_Checks equals Total_Checks.
